lfsr_gen: RTL

- Parametrised successor to the team's fixed 8-bit TinyTapeout LFSR.
- Generalises width, tap mask and topology (Fibonacci/Galois), and adds seed load, free-run, counted-burst and single-step control through a command handshake.
- Sits behind the tt_um_* wrapper: ui_in/uio_in drive commands, uo_out/uio_out carry state bits.

---
 rtl/lfsr_gen_pkg.sv | 30 +++
 rtl/lfsr_next.sv | 19 +
 rtl/lfsr_gen.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/lfsr_gen_pkg.sv
// Shared types and default tap masks for the parametrised LFSR generator.
package lfsr_gen_pkg;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'd0,
    OP_RUN   = 2'd1,
    OP_BURST = 2'd2,
    OP_STOP  = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_BURST = 2'd2
  } fsm_t;

  localparam logic [7:0]  TAPS8  = 8'hB8;
  localparam logic [15:0] TAPS16 = 16'hB400;
  localparam logic [31:0] TAPS32 = 32'h80200003;

  // Maximal-length mask for the common widths; other widths must pass TAPS explicitly.
  function automatic logic [31:0] default_taps(input int w);
    case (w)
      8:       return {24'd0, TAPS8};
      32:      return TAPS32;
      default: return {16'd0, TAPS16};
    endcase
  endfunction

endpackage

// File: rtl/lfsr_next.sv
// Combinational single-step advance of an LFSR, Fibonacci (shift-left) or Galois (shift-right).
module lfsr_next #(
  parameter int               WIDTH  = 16,
  parameter logic [WIDTH-1:0] TAPS   = 16'hB400,
  parameter bit               GALOIS = 1'b0
) (
  input  logic [WIDTH-1:0] cur,
  output logic [WIDTH-1:0] nxt
);

  generate
    if (GALOIS) begin : g_galois
      assign nxt = (cur >> 1) ^ (cur[0] ? TAPS : '0);
    end else begin : g_fib
      assign nxt = {cur[WIDTH-2:0], ^(cur & TAPS)};
    end
  endgenerate

endmodule

// File: rtl/lfsr_gen.sv
// Command-driven LFSR generator with load/run/burst/step control.
// Optional period counter and wrap detection enabled by defining LFSR_PERIOD_EN.
module lfsr_gen
  import lfsr_gen_pkg::*;
#(
  parameter int               WIDTH  = 16,
  parameter logic [WIDTH-1:0] TAPS   = WIDTH'(default_taps(WIDTH)),
  parameter bit               GALOIS = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_arg,
  input  logic             step,
  output logic [WIDTH-1:0] state_o,
  output logic             bit_o,
  output logic             adv_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             wrap_o,
  output logic [WIDTH-1:0] period_o
);

  fsm_t             fsm_q, fsm_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d, lfsr_nxt;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] load_val;
  logic             adv_q, done_q;
  logic             do_adv, done_d, do_load;
  op_t              op;

  assign op       = op_t'(cmd_op);
  assign load_val = (cmd_arg == '0) ? WIDTH'(1) : cmd_arg;

  lfsr_next #(.WIDTH(WIDTH), .TAPS(TAPS), .GALOIS(GALOIS)) u_next (
    .cur (lfsr_q),
    .nxt (lfsr_nxt)
  );

  // Commands pre-empt any advance in the cycle they are accepted.
  always_comb begin
    fsm_d   = fsm_q;
    cnt_d   = cnt_q;
    do_adv  = 1'b0;
    done_d  = 1'b0;
    do_load = 1'b0;
    if (ena) begin
      if (cmd_valid) begin
        case (op)
          OP_LOAD: begin
            do_load = 1'b1;
            fsm_d   = S_IDLE;
          end
          OP_RUN: fsm_d = S_RUN;
          OP_BURST: begin
            cnt_d = cmd_arg;
            if (cmd_arg == '0) begin
              fsm_d  = S_IDLE;
              done_d = 1'b1;
            end else begin
              fsm_d = S_BURST;
            end
          end
          default: begin
            fsm_d = S_IDLE;
            cnt_d = '0;
          end
        endcase
      end else begin
        case (fsm_q)
          S_RUN:   do_adv = 1'b1;
          S_BURST: begin
            do_adv = 1'b1;
            cnt_d  = cnt_q - WIDTH'(1);
            if (cnt_q == WIDTH'(1)) begin
              fsm_d  = S_IDLE;
              done_d = 1'b1;
            end
          end
          default: do_adv = step;
        endcase
      end
    end
  end

  always_comb begin
    lfsr_d = lfsr_q;
    if (do_load)     lfsr_d = load_val;
    else if (do_adv) lfsr_d = lfsr_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q  <= S_IDLE;
      lfsr_q <= WIDTH'(1);
      cnt_q  <= '0;
      adv_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      fsm_q  <= fsm_d;
      lfsr_q <= lfsr_d;
      cnt_q  <= cnt_d;
      adv_q  <= do_adv;
      done_q <= done_d;
    end
  end

`ifdef LFSR_PERIOD_EN
  logic [WIDTH-1:0] seed_q, period_q;
  logic             wrap_q;

  // Wrap is detected on the advanced value so period restarts in the same update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seed_q   <= WIDTH'(1);
      period_q <= '0;
      wrap_q   <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (do_load) begin
        seed_q   <= load_val;
        period_q <= '0;
      end else if (do_adv) begin
        if (lfsr_nxt == seed_q) begin
          wrap_q   <= 1'b1;
          period_q <= '0;
        end else begin
          period_q <= period_q + WIDTH'(1);
        end
      end
    end
  end

  assign wrap_o   = wrap_q;
  assign period_o = period_q;
`else
  assign wrap_o   = 1'b0;
  assign period_o = '0;
`endif

  assign cmd_ready = ena;
  assign state_o   = lfsr_q;
  assign bit_o     = lfsr_q[0];
  assign adv_o     = adv_q;
  assign done_o    = done_q;
  assign busy_o    = (fsm_q == S_RUN) || (fsm_q == S_BURST);

endmodule
